// File: rtl/mul_div_unit_if.sv
// Handshake and data bundle between the execute stage and the multiply/divide unit.
`timescale 1ns/1ps
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; one iteration per cycle over WIDTH cycles.
// Optional MULDIV_EARLY_OUT_EN: zero divisor / zero multiply operand skips straight to FIX.
`timescale 1ns/1ps
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             is_div_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;
    logic [WIDTH-1:0] opnd_reg;

    // Operand magnitudes; unsigned ops (op[0]=1) pass raw values through.
    logic             signed_op;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign signed_op = ~bus.op[0];
    assign sign_a    = signed_op & bus.a[WIDTH-1];
    assign sign_b    = signed_op & bus.b[WIDTH-1];
    assign mag_a     = sign_a ? -bus.a : bus.a;
    assign mag_b     = sign_b ? -bus.b : bus.b;

`ifdef MULDIV_EARLY_OUT_EN
    logic early_out;
    assign early_out = (bus.b == '0) || (!bus.op[1] && (bus.a == '0));
`endif

    // Multiply: {acc_hi, acc_lo} starts as {0, |b|} and shifts right, adding |a| on a set LSB.
    // Divide: acc_lo holds the dividend shifting out at the top and the quotient shifting in.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd_reg});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_reg;

    always_comb begin
        iter_hi = mul_sum[WIDTH:1];
        iter_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        if (is_div_reg) begin
            iter_hi = div_ok ? div_diff : div_shift[WIDTH-1:0];
            iter_lo = {acc_lo_reg[WIDTH-2:0], div_ok};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign prod_fix = neg_q_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
    assign quo_fix  = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
    assign rem_fix  = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
    assign res_hi   = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opnd_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.hi_we) hi_reg <= bus.wdata;
                    if (bus.lo_we) lo_reg <= bus.wdata;
                    if (bus.start) begin
                        is_div_reg <= bus.op[1];
                        neg_q_reg  <= sign_a ^ sign_b;
                        neg_r_reg  <= sign_a;
                        opnd_reg   <= bus.op[1] ? mag_b : mag_a;
                        acc_hi_reg <= '0;
                        acc_lo_reg <= bus.op[1] ? mag_a : mag_b;
                        count_reg  <= CNT_INIT;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_RUN;
`ifdef MULDIV_EARLY_OUT_EN
                        // Preload the magnitudes the full iteration would have produced.
                        if (early_out) begin
                            acc_hi_reg <= bus.op[1] ? mag_a : '0;
                            acc_lo_reg <= bus.op[1] ? '1 : '0;
                            state_reg  <= ST_FIX;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    acc_hi_reg <= iter_hi;
                    acc_lo_reg <= iter_lo;
                    count_reg  <= count_reg - CNT_W'(1);
                    if (count_reg == '0) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_reg    <= res_hi;
                    lo_reg    <= res_lo;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule
